// File: rtl/softmax_job_arbiter.sv
// Round-robin arbiter sharing one softmax engine between NREQ requesters.
// One job in flight at a time; a watchdog converts a silent engine into an error response.
module softmax_job_arbiter #(
  parameter int N       = 64,
  parameter int W       = 16,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*N*W-1:0]  req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic [N*W-1:0]       sm_x_in,
  output logic                 sm_x_in_valid,
  input  logic                 sm_ready,
  input  logic                 sm_valid,
  input  logic [N*W-1:0]       sm_out,
  output logic                 sm_next_ready,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [N*W-1:0]       rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [7:0]           timeout_cnt
);

  localparam int VW = N * W;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [VW-1:0]   vec_q;
  logic [VW-1:0]   result_q;
  logic            err_q;
  logic [TW-1:0]   timer_q;
  logic [7:0]      tcnt_q;

  logic [NREQ-1:0] req_rot;
  logic [PW:0]     rot_idx;
  logic [PW:0]     grant_sum;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic            timeout_hit;

  // Rotate the requests so the pointer position sits at bit 0, then take the lowest set bit.
  always_comb begin
    req_rot = '0;
    rot_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      rot_idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (rot_idx >= (PW+1)'(NREQ))
        rot_idx = rot_idx - (PW+1)'(NREQ);
      req_rot[k] = req_valid[rot_idx[PW-1:0]];
    end
    grant_any = |req_rot;
    grant_sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k])
        grant_sum = (PW+1)'(k) + {1'b0, rr_ptr};
    end
    if (grant_sum >= (PW+1)'(NREQ))
      grant_idx = PW'(grant_sum - (PW+1)'(NREQ));
    else
      grant_idx = PW'(grant_sum);
  end

  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TLAST);

  // Gated by rst_n so the accept strobe is also quiet while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == S_IDLE) && grant_any)
      req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_any) state_nxt = S_ISSUE;
      S_ISSUE: if (sm_ready) state_nxt = S_WAIT;
      S_WAIT:  if (sm_valid || timeout_hit) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready[owner]) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Datapath: capture on grant, time the engine, latch result or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      owner    <= '0;
      vec_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      timer_q  <= '0;
      tcnt_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            vec_q <= req_x[int'(grant_idx)*VW +: VW];
            owner <= grant_idx;
            if (grant_idx == PW'(NREQ - 1))
              rr_ptr <= '0;
            else
              rr_ptr <= grant_idx + PW'(1);
          end
        end
        S_ISSUE: begin
          if (sm_ready)
            timer_q <= '0;
        end
        S_WAIT: begin
          timer_q <= timer_q + TW'(1);
          if (sm_valid) begin
            result_q <= sm_out;
            err_q    <= 1'b0;
          end else if (timeout_hit) begin
            result_q <= '0;
            err_q    <= 1'b1;
            if (tcnt_q != 8'hFF)
              tcnt_q <= tcnt_q + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state == S_RESP)
      rsp_valid[owner] = 1'b1;
  end

  assign sm_x_in       = vec_q;
  assign sm_x_in_valid = (state == S_ISSUE);
  assign sm_next_ready = (state == S_WAIT);
  assign rsp_data      = result_q;
  assign rsp_err       = err_q;
  assign busy          = (state != S_IDLE);
  assign timeout_cnt   = tcnt_q;

endmodule

// File: doc/softmax_job_arbiter.md
Name: softmax_job_arbiter

Overview:
- Shares one softmax engine (N-element, FP16, valid/ready) between NREQ requesters, e.g. the UART host path and on-chip test/attention clients.
- Grants requesters round-robin and captures the granted vector; one job in flight at a time.
- Collects the engine result and returns it to the owning requester with a response handshake.
- Watchdog aborts jobs the engine never completes.

Parameters:
N, 64, elements per vector
W, 16, bits per element (FP16)
NREQ, 4, number of requesters (2..8)
TIMEOUT, 4096, max cycles waiting for engine result; 0 disables watchdog

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester job request
req_x  in  NREQ*N*W  requester vectors; requester k at [k*N*W +: N*W]
req_ready  out  NREQ  one-hot job accept
sm_x_in  out  N*W  vector to engine
sm_x_in_valid  out  1  engine input valid
sm_ready  in  1  engine input ready
sm_valid  in  1  engine result valid
sm_out  in  N*W  engine result
sm_next_ready  out  1  ready to engine output side
rsp_valid  out  NREQ  one-hot response valid
rsp_ready  in  NREQ  per-requester response accept
rsp_data  out  N*W  result vector (shared bus)
rsp_err  out  1  response is a timeout abort (rsp_data all zero)
busy  out  1  high in any state other than S_IDLE
timeout_cnt  out  8  saturating count of aborted jobs

Behaviour:
- Reset: all outputs 0; state S_IDLE; rr pointer = 0; owner, captured vector, result, timer cleared. Asserting reset in any state aborts the job silently: no response, no count.
- rr pointer p: search order p, p+1, ..., wrapping mod NREQ; the first asserted req_valid wins.
- S_IDLE: if any req_valid, assert req_ready[g] for exactly that cycle (combinational from req_valid and p). Capture req_x slice g into the vector register and g into owner. Set p = (g+1) mod NREQ. Go to S_ISSUE. Otherwise stay.
- Requesters must hold req_valid and req_x until req_ready. Dropping req_valid before grant is legal; that request is simply not granted.
- S_ISSUE: sm_x_in = captured vector, held stable. sm_x_in_valid = 1 while in state. The transfer occurs on the cycle sm_x_in_valid and sm_ready are both high; then go to S_WAIT and clear the timer. sm_x_in_valid is 0 outside S_ISSUE.
- S_WAIT: sm_next_ready = 1 (0 in all other states). On sm_valid, register sm_out into the result register, clear rsp_err, go to S_RESP.
  - Timer increments each S_WAIT cycle. If TIMEOUT != 0 and the timer reaches TIMEOUT without sm_valid: result = 0, rsp_err = 1, timeout_cnt += 1 (saturate at 255), go to S_RESP.
  - If sm_valid arrives on the same cycle the timer reaches TIMEOUT, sm_valid wins and the job is not an abort.
- S_RESP: rsp_valid[owner] = 1; rsp_data and rsp_err held stable. Hold until rsp_ready[owner]; then go to S_IDLE. rsp_ready of non-owners is ignored. Unbounded backpressure is allowed.
- Stray sm_valid outside S_WAIT is ignored, and sm_next_ready is low then.
- Job latency from grant to rsp_valid = 1 (S_ISSUE entry) + sm_ready wait + engine latency + 1 (result register).
- A new grant cannot occur in the cycle a response completes; the earliest next req_ready is the following cycle.
- req_ready, rsp_valid and sm_x_in_valid are never asserted simultaneously.
- All state transitions are registered; req_ready is the only combinational output.

Test Plan:
- Single job: req_valid[1] only, engine model latency 10, element j = j -> req_ready[1] one cycle; sm_x_in_valid one cycle; rsp_valid[1] 11 cycles after issue; rsp_data equals model output; rsp_err = 0.
- Fairness: req_valid = 4'b1111 held throughout -> grant order 0,1,2,3,0; each rsp_valid is one-hot to the matching owner. Then req_valid = 4'b0101 with p = 1 -> grant 2, then 0.
- Backpressure: sm_ready low 5 cycles in S_ISSUE, then rsp_ready low 20 cycles -> sm_x_in_valid held high 6 cycles; rsp_valid/rsp_data stable 21 cycles; no grants meanwhile; busy stays 1.
- Timeout: TIMEOUT = 16, engine never asserts sm_valid -> rsp_valid after 16 S_WAIT cycles with rsp_err = 1, rsp_data = 0, timeout_cnt = 1. Next job completes normally.
- Timeout tie: sm_valid exactly on cycle 16 -> rsp_err = 0, data from sm_out, timeout_cnt unchanged.
- Reset mid-job: rst_n low during S_WAIT -> all outputs 0 immediately. After release, a stray sm_valid is ignored; the next request to 0 is granted first (p = 0).
